// File: rtl/fetch_line_streamer_pkg.sv
// Shared types and line geometry for the fetch line streamer.
package fetch_pkg;

  localparam int LINE_WORDS       = 16;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int WORD_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM
  } fetch_state_t;

endpackage

// File: rtl/fetch_line_streamer_if.sv
// Redirect, line-fetcher and decoder-side signals of the fetch line streamer.
interface fetch_line_streamer_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int INSTR_WIDTH    = 32
);
  logic                          redirect_valid;
  logic [BUS_DATA_WIDTH-1:0]     redirect_pc;
  logic                          fetch_enable;
  logic [BUS_DATA_WIDTH-1:0]     fetch_addr;
  logic                          fetch_ready;
  logic [BUS_DATA_WIDTH*8-1:0]   fetch_data;
  logic                          instr_valid;
  logic [INSTR_WIDTH-1:0]        instr;
  logic [BUS_DATA_WIDTH-1:0]     instr_pc;
  logic                          instr_ready;

  modport master (
    input  redirect_valid, redirect_pc, fetch_ready, fetch_data, instr_ready,
    output fetch_enable, fetch_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, fetch_ready, fetch_data, instr_ready,
    input  fetch_enable, fetch_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_line_streamer_line_word_select.sv
// Combinational word mux: picks word idx out of a held cache line, zero latency.
module line_word_select #(
  parameter int LINE_W = 512,
  parameter int WORD_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic [LINE_W-1:0] line,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < LINE_W / WORD_W; i++) begin
      if (idx == IDX_W'(i)) word = line[i*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/fetch_line_streamer.sv
// Fetch line streamer: redirect->fetch_enable 1 cycle, fetch_ready->instr_valid 1 cycle, instr_ready low stalls.
// Optional FETCH_LINE_REUSE_EN: redirects inside the held line stay in STREAM without refetching.
module fetch_line_streamer
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LINE_BYTES     = 64,
  parameter int INSTR_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_line_streamer_if.master  bus
);

  localparam int LINE_W = BUS_DATA_WIDTH * 8;
  localparam int IDX_W  = LINE_OFFSET_BITS - WORD_OFFSET_BITS;

  fetch_state_t              state;
  logic [BUS_DATA_WIDTH-1:0] pc;
  logic [BUS_DATA_WIDTH-1:0] line_addr;
  logic [LINE_W-1:0]         line;
  logic                      stale;
  logic                      seen_low;

  logic [BUS_DATA_WIDTH-1:0] redirect_al;
  logic [BUS_DATA_WIDTH-1:0] pc_seq;
  logic                      line_ok;
  logic                      last_word;
  logic                      same_line;
  logic [INSTR_WIDTH-1:0]    word;

  function automatic logic [BUS_DATA_WIDTH-1:0] line_base(input logic [BUS_DATA_WIDTH-1:0] a);
    return {a[BUS_DATA_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

  assign redirect_al = bus.redirect_pc & ~BUS_DATA_WIDTH'(3);
  assign pc_seq      = pc + BUS_DATA_WIDTH'(4);
  // A ready level carried over from the previous line must drop before it counts.
  assign line_ok     = bus.fetch_ready & seen_low;
  assign last_word   = &pc[LINE_OFFSET_BITS-1:WORD_OFFSET_BITS];

`ifdef FETCH_LINE_REUSE_EN
  assign same_line = (bus.redirect_pc[BUS_DATA_WIDTH-1:LINE_OFFSET_BITS] ==
                      line_addr[BUS_DATA_WIDTH-1:LINE_OFFSET_BITS]);
`else
  assign same_line = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      line_addr <= '0;
      line      <= '0;
      stale     <= 1'b0;
      seen_low  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect_valid) begin
            pc        <= redirect_al;
            line_addr <= line_base(redirect_al);
            state     <= REQ;
          end
        end
        REQ: begin
          seen_low <= 1'b0;
          state    <= WAIT;
          if (bus.redirect_valid) begin
            pc    <= redirect_al;
            stale <= 1'b1;
          end
        end
        WAIT: begin
          if (!bus.fetch_ready) seen_low <= 1'b1;
          if (bus.redirect_valid) pc <= redirect_al;
          if (line_ok) begin
            // The fetcher cannot be aborted, so a stale line is dropped and the newest pc refetched.
            if (stale || bus.redirect_valid) begin
              stale     <= 1'b0;
              line_addr <= line_base(bus.redirect_valid ? redirect_al : pc);
              state     <= REQ;
            end else begin
              line  <= bus.fetch_data;
              state <= STREAM;
            end
          end else if (bus.redirect_valid) begin
            stale <= 1'b1;
          end
        end
        STREAM: begin
          if (bus.redirect_valid) begin
            pc <= redirect_al;
            if (!same_line) begin
              line_addr <= line_base(redirect_al);
              state     <= REQ;
            end
          end else if (bus.instr_ready) begin
            pc <= pc_seq;
            if (last_word) begin
              line_addr <= line_base(pc_seq);
              state     <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  line_word_select #(
    .LINE_W (LINE_W),
    .WORD_W (INSTR_WIDTH),
    .IDX_W  (IDX_W)
  ) u_word_select (
    .line (line),
    .idx  (pc[LINE_OFFSET_BITS-1:WORD_OFFSET_BITS]),
    .word (word)
  );

  assign bus.fetch_enable = (state == REQ);
  assign bus.fetch_addr   = line_addr;
  assign bus.instr_valid  = (state == STREAM);
  assign bus.instr        = word;
  assign bus.instr_pc     = pc;

endmodule

// File: tb/tb_fetch_line_streamer.sv
// Scoreboarded bench for fetch_line_streamer with a behavioural line-fetcher model.
module tb_fetch_line_streamer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_line_streamer_if #(.BUS_DATA_WIDTH(64), .INSTR_WIDTH(32)) bus ();

  fetch_line_streamer #(.BUS_DATA_WIDTH(64), .LINE_BYTES(64), .INSTR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] fetch_q[$];
  int          pop_times[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          ready_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Fetcher returns word k of line a as a[35:4] + k.
  function automatic logic [511:0] line_of(input logic [63:0] a);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = a[35:4] + 32'(k);
    return r;
  endfunction

  // Line fetcher: drops ready after a request, returns the line 4 cycles later, then holds ready.
  initial begin
    logic [63:0] fa;
    bus.fetch_ready = 1'b1;
    bus.fetch_data  = {16{32'hEEEE_EEEE}};
    forever begin
      @(negedge clk);
      if (bus.fetch_enable) begin
        fa = bus.fetch_addr;
        bus.fetch_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus.fetch_data  = line_of(fa);
        bus.fetch_ready = 1'b1;
        ready_cyc       = cyc;
      end
    end
  end

  // Monitor: instruction fires and fetch requests against their queues.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      pop_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("instr_unexpected_pc", bus.instr_pc, 64'hXXXX_XXXX_XXXX_XXXX);
      end else begin
        e = exp_q.pop_front();
        chk("instr", {32'h0, bus.instr}, {32'h0, e.ins});
        chk("instr_pc", bus.instr_pc, e.pc);
      end
    end
    if (!reset && bus.fetch_enable) begin
      if (fetch_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fetch_unexpected: got addr %h expected no request", bus.fetch_addr);
      end else begin
        chk("fetch_addr", bus.fetch_addr, fetch_q.pop_front());
      end
    end
  end

  task automatic push_line(input logic [63:0] pc0, input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++)
      exp_q.push_back('{ins: base + 32'(k), pc: pc0 + 64'(4*k)});
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fetch_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0 || fetch_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d instr/%0d fetch pending expected 0", name, exp_q.size(), fetch_q.size());
      exp_q.delete();
      fetch_q.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    for (int n = 0; n < 30 && !bus.instr_valid; n++) begin
      @(posedge clk); #1;
    end
    chk(name, {63'h0, bus.instr_valid}, 64'h1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fetch_enable"}, {63'h0, bus.fetch_enable}, 64'h0);
    chk({tag, "_fetch_addr"}, bus.fetch_addr, 64'h0);
    chk({tag, "_instr_valid"}, {63'h0, bus.instr_valid}, 64'h0);
    chk({tag, "_instr"}, {32'h0, bus.instr}, 64'h0);
    chk({tag, "_instr_pc"}, bus.instr_pc, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    #1;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Full line from 0x1000, then sequential refetch of 0x1040.
    pop_times.delete();
    fetch_q.push_back(64'h1000);
    push_line(64'h1000, 16, 32'h100);
    fetch_q.push_back(64'h1040);
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1000;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redirect_to_fetch_enable", {63'h0, bus.fetch_enable}, 64'h1);
    drain("line_1000", 60);
    bus.instr_ready = 1'b0;
    chk("line_1000_count", 64'(pop_times.size()), 64'd16);
    if (pop_times.size() == 16) begin
      chk("line_1000_back_to_back", 64'(pop_times[15] - pop_times[0]), 64'd15);
      chk("ready_to_valid_latency", 64'(pop_times[0]), 64'(ready_cyc + 1));
    end

    // Stall 10 cycles on line 0x1040, then redirect to 0x2038 while a fire is offered.
    wait_valid("line_1040_valid");
    repeat (10) begin
      @(negedge clk);
      chk("stall_instr", {32'h0, bus.instr}, 64'h104);
      chk("stall_pc", bus.instr_pc, 64'h1040);
    end
    @(posedge clk); #1;
    exp_q.push_back('{ins: 32'h104, pc: 64'h1040});
    fetch_q.push_back(64'h2000);
    exp_q.push_back('{ins: 32'h20E, pc: 64'h2038});
    exp_q.push_back('{ins: 32'h20F, pc: 64'h203C});
    fetch_q.push_back(64'h2040);
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2038;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    drain("line_2000", 40);
    bus.instr_ready = 1'b0;

    // Redirect to 0x3000, then two redirects during WAIT; the last (0x5004) wins.
    wait_valid("line_2040_valid");
    fetch_q.push_back(64'h3000);
    fetch_q.push_back(64'h5000);
    exp_q.push_back('{ins: 32'h501, pc: 64'h5004});
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3000;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h4000;
    @(posedge clk); #1;
    bus.redirect_pc    = 64'h5006;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    drain("stale_5004", 40);
    bus.instr_ready = 1'b0;

    // Top-of-address-space wrap, then async reset in the following WAIT.
    fetch_q.push_back(64'hFFFF_FFFF_FFFF_FFC0);
    exp_q.push_back('{ins: 32'h0000_000B, pc: 64'hFFFF_FFFF_FFFF_FFFC});
    fetch_q.push_back(64'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    drain("wrap", 40);
    bus.instr_ready = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_fetch_enable", {63'h0, bus.fetch_enable}, 64'h0);
      chk("idle_instr_valid", {63'h0, bus.instr_valid}, 64'h0);
    end

    // Redirect inside the held line 0x1000.
    @(posedge clk); #1;
    fetch_q.push_back(64'h1000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1000;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    wait_valid("reuse_line_valid");
    @(negedge clk);
    chk("reuse_first_instr", {32'h0, bus.instr}, 64'h100);
    @(posedge clk); #1;
`ifdef FETCH_LINE_REUSE_EN
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1010;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("reuse_valid", {63'h0, bus.instr_valid}, 64'h1);
    chk("reuse_instr", {32'h0, bus.instr}, 64'h104);
    chk("reuse_pc", bus.instr_pc, 64'h1010);
    repeat (3) @(negedge clk);
`else
    fetch_q.push_back(64'h1000);
    exp_q.push_back('{ins: 32'h104, pc: 64'h1010});
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1010;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    drain("refetch_1010", 40);
    bus.instr_ready = 1'b0;
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
